// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: shared segment type, hex segment codes and reader FSM states
package seven_segment_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_HEX_0 = 7'b1111110;
    localparam seg_t SEG_HEX_1 = 7'b0110000;
    localparam seg_t SEG_HEX_2 = 7'b1101101;
    localparam seg_t SEG_HEX_3 = 7'b1111001;
    localparam seg_t SEG_HEX_4 = 7'b0110011;
    localparam seg_t SEG_HEX_5 = 7'b1011011;
    localparam seg_t SEG_HEX_6 = 7'b1011111;
    localparam seg_t SEG_HEX_7 = 7'b1110000;
    localparam seg_t SEG_HEX_8 = 7'b1111111;
    localparam seg_t SEG_HEX_9 = 7'b1111011;
    localparam seg_t SEG_HEX_A = 7'b1110111;
    localparam seg_t SEG_HEX_B = 7'b0011111;
    localparam seg_t SEG_HEX_C = 7'b1001110;
    localparam seg_t SEG_HEX_D = 7'b0111101;
    localparam seg_t SEG_HEX_E = 7'b1001111;
    localparam seg_t SEG_HEX_F = 7'b1000111;
    typedef enum logic [1:0] {IDLE, QUALIFY, CAPTURE, WAIT} reader_state_t;
endpackage

// File: rtl/seven_segment_encoder.sv
// seven_segment_encoder: maps a segment pattern back to its hex nibble.
// Ports: seg_i pattern {a..g}; hex_o nibble (0 when illegal); legal_o pattern is a hex code.
module seven_segment_encoder
    import seven_segment_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] hex_o,
    output logic       legal_o
);
    always_comb begin
        hex_o = 4'h0;
        legal_o = 1'b1;
        case (seg_i)
            SEG_HEX_0: hex_o = 4'h0;
            SEG_HEX_1: hex_o = 4'h1;
            SEG_HEX_2: hex_o = 4'h2;
            SEG_HEX_3: hex_o = 4'h3;
            SEG_HEX_4: hex_o = 4'h4;
            SEG_HEX_5: hex_o = 4'h5;
            SEG_HEX_6: hex_o = 4'h6;
            SEG_HEX_7: hex_o = 4'h7;
            SEG_HEX_8: hex_o = 4'h8;
            SEG_HEX_9: hex_o = 4'h9;
            SEG_HEX_A: hex_o = 4'hA;
            SEG_HEX_B: hex_o = 4'hB;
            SEG_HEX_C: hex_o = 4'hC;
            SEG_HEX_D: hex_o = 4'hD;
            SEG_HEX_E: hex_o = 4'hE;
            SEG_HEX_F: hex_o = 4'hF;
            default:   legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/seven_segment_scan_reader.sv
// seven_segment_scan_reader: reads back a multiplexed seven-segment bus into per-digit hex frames.
// Ports: clk, rst (async, active-high); seg_in {a..g}; dig_in one-hot strobes;
// hex_out published nibbles; frame_valid one-cycle publish pulse; digit_err illegal-pattern flags.
// Option SEVEN_SEGMENT_READER_DP_EN adds dp_in (sampled decimal point) and dp_out (published per digit).
module seven_segment_scan_reader
    import seven_segment_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_in,
`ifdef SEVEN_SEGMENT_READER_DP_EN
    input  logic                  dp_in,
    output logic [DIGITS-1:0]     dp_out,
`endif
    output logic [4*DIGITS-1:0]   hex_out,
    output logic                  frame_valid,
    output logic [DIGITS-1:0]     digit_err
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
`ifdef SEVEN_SEGMENT_READER_DP_EN
    localparam int VW = 8 + DIGITS;
`else
    localparam int VW = 7 + DIGITS;
`endif
    seg_t                seg_q;
    logic [DIGITS-1:0]   dig_q;
    logic [VW-1:0]       cur, prev_q;
    reader_state_t       state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DIGITS-1:0]   seen_q, seen_d, err_sh_q, err_sh_d, err_q;
    logic [4*DIGITS-1:0] hex_sh_q, hex_sh_d, hex_q;
    logic                fv_q, one_hot, changed, capture, full;
    logic [3:0]          hex;
    logic                legal;

    seven_segment_encoder u_enc (.seg_i(seg_q), .hex_o(hex), .legal_o(legal));

    assign hex_out     = hex_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;

`ifdef SEVEN_SEGMENT_READER_DP_EN
    logic              dp_q;
    logic [DIGITS-1:0] dp_sh_q, dp_sh_d, dp_pub_q;
    assign cur    = {dp_q, seg_q, dig_q};
    assign dp_out = dp_pub_q;
    always_comb begin
        dp_sh_d = dp_sh_q;
        for (int i = 0; i < DIGITS; i++)
            if (capture && dig_q[i]) dp_sh_d[i] = dp_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_q     <= 1'b0;
            dp_sh_q  <= '0;
            dp_pub_q <= '0;
        end else begin
            dp_q    <= dp_in;
            dp_sh_q <= dp_sh_d;
            if (full) dp_pub_q <= dp_sh_q;
        end
    end
`else
    assign cur = {seg_q, dig_q};
`endif

    always_comb begin
        one_hot = $onehot(dig_q);
        changed = cur != prev_q;
        cnt_d   = !one_hot ? '0 : changed ? CW'(1) : (cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1));
        // once a window has been captured, stay parked until the bus value moves
        state_d = !one_hot ? IDLE
                : (!changed && (state_q == CAPTURE || state_q == WAIT)) ? WAIT
                : (cnt_d == CNT_MAX ? CAPTURE : QUALIFY);
        capture = state_d == CAPTURE;
        full    = &seen_q;
        // the clear from a completed frame is applied before a coincident new capture
        seen_d   = (full ? '0 : seen_q) | (capture ? dig_q : '0);
        hex_sh_d = hex_sh_q;
        err_sh_d = err_sh_q;
        for (int i = 0; i < DIGITS; i++)
            if (capture && dig_q[i]) begin
                hex_sh_d[4*i +: 4] = hex;
                err_sh_d[i]        = !legal;
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q    <= '0;
            dig_q    <= '0;
            prev_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            seen_q   <= '0;
            hex_sh_q <= '0;
            err_sh_q <= '0;
            hex_q    <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
        end else begin
            seg_q    <= seg_in;
            dig_q    <= dig_in;
            prev_q   <= cur;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            hex_sh_q <= hex_sh_d;
            err_sh_q <= err_sh_d;
            fv_q     <= full;
            if (full) begin
                hex_q <= hex_sh_q;
                err_q <= err_sh_q;
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// tb_seven_segment_scan_reader: directed and random scans checked against a run-length frame model.
module tb_seven_segment_scan_reader;
    localparam int D = 4;
    localparam int S = 3;
`ifdef SEVEN_SEGMENT_READER_DP_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif
    typedef struct {
        logic [4*D-1:0] hex;
        logic [D-1:0]   err;
        logic [D-1:0]   dp;
    } frame_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [6:0]     seg_in = '0;
    logic [D-1:0]   dig_in = '0;
    logic           dp_in = 1'b0;
    logic [4*D-1:0] hex_out;
    logic           frame_valid;
    logic [D-1:0]   digit_err;
    logic [D-1:0]   dp_val;

    seven_segment_scan_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .dig_in(dig_in),
`ifdef SEVEN_SEGMENT_READER_DP_EN
        .dp_in(dp_in),
        .dp_out(dp_val),
`endif
        .hex_out(hex_out),
        .frame_valid(frame_valid),
        .digit_err(digit_err)
    );
`ifndef SEVEN_SEGMENT_READER_DP_EN
    assign dp_val = '0;
`endif

    always #5 clk = ~clk;

    logic [6:0] tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    int n_chk = 0, n_pass = 0;
    frame_t obs_q[$], exp_q[$];

    logic [4*D-1:0] m_hex;
    logic [D-1:0]   m_err, m_dp, m_seen;
    logic [6:0]     run_seg;
    logic [D-1:0]   run_dig;
    logic           run_dp;
    int             run_len;

    always @(negedge clk)
        if (frame_valid) obs_q.push_back('{hex_out, digit_err, dp_val});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_hex = '0; m_err = '0; m_dp = '0; m_seen = '0;
        run_seg = '0; run_dig = '0; run_dp = 1'b0; run_len = 0;
    endtask

    // a run of one value lasting at least S samples with a single strobe yields one capture
    task automatic finish_run();
        int idx;
        logic [3:0] h;
        logic ok;
        if ($countones(run_dig) != 1 || run_len < S) return;
        idx = 0;
        for (int i = 0; i < D; i++) if (run_dig[i]) idx = i;
        h = 4'h0; ok = 1'b0;
        for (int v = 0; v < 16; v++) if (tab[v] == run_seg) begin h = 4'(v); ok = 1'b1; end
        m_hex[4*idx +: 4] = h;
        m_err[idx] = !ok;
        m_dp[idx] = run_dp;
        m_seen[idx] = 1'b1;
        if (&m_seen) begin
            exp_q.push_back('{m_hex, m_err, m_dp});
            m_seen = '0;
        end
    endtask

    task automatic window(input logic [6:0] s, input logic [D-1:0] d, input logic p, input int len);
        logic pe;
        pe = DP_ON ? p : 1'b0;
        if (s == run_seg && d == run_dig && pe == run_dp) run_len += len;
        else begin
            finish_run();
            run_seg = s; run_dig = d; run_dp = pe; run_len = len;
        end
        seg_in = s; dig_in = d; dp_in = p;
        repeat (len) @(negedge clk);
    endtask

    task automatic drain();
        window(7'h00, '0, 1'b0, 4);
    endtask

    task automatic check_frames(input string tag);
        int n;
        check({tag, "_frames"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_hex"}, 64'(obs_q[i].hex), 64'(exp_q[i].hex));
            check({tag, "_err"}, 64'(obs_q[i].err), 64'(exp_q[i].err));
            if (DP_ON) check({tag, "_dp"}, 64'(obs_q[i].dp), 64'(exp_q[i].dp));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic scan(input logic [15:0] vals, input logic [D-1:0] dpm, input int len);
        for (int i = D - 1; i >= 0; i--)
            window(tab[vals[4*i +: 4]], D'(1) << i, dpm[i], len);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_hex", 64'(hex_out), 64'h0);
        check("rst_fv", 64'(frame_valid), 64'h0);
        check("rst_err", 64'(digit_err), 64'h0);
        check("rst_dp", 64'(dp_val), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        scan(16'h3210, 4'b0001, 5);
        drain();
        check("scan_hex", 64'(hex_out), 64'h3210);
        check("scan_err", 64'(digit_err), 64'h0);
        if (DP_ON) check("scan_dp", 64'(dp_val), 64'h1);
        check_frames("scan");

        window(tab[3], 4'b1000, 1'b0, 5);
        window(tab[2], 4'b0100, 1'b0, 5);
        window(7'b1010101, 4'b0010, 1'b0, 5);
        window(tab[0], 4'b0001, 1'b0, 5);
        drain();
        check("bad_err", 64'(digit_err), 64'h2);
        check("bad_nib", 64'(hex_out[7:4]), 64'h0);
        check("bad_hex", 64'(hex_out), 64'h3000 | 64'h0200);
        check_frames("bad");

        window(tab[7], 4'b1000, 1'b0, 5);
        window(tab[6], 4'b0100, 1'b0, 2);
        window(tab[5], 4'b0010, 1'b0, 5);
        window(tab[4], 4'b0001, 1'b0, 5);
        drain();
        check("short_nofv", 64'(obs_q.size()), 64'h0);
        check_frames("short");
        window(tab[6], 4'b0100, 1'b0, 3);
        drain();
        check("short_hex", 64'(hex_out), 64'h7654);
        check_frames("short2");

        window(tab[9], 4'b0011, 1'b0, 5);
        window(tab[8], 4'b0000, 1'b0, 5);
        window(tab[1], 4'b1100, 1'b0, 5);
        drain();
        check_frames("multi");
        scan(16'h9ABC, 4'b0000, 4);
        drain();
        check("clean_hex", 64'(hex_out), 64'h9ABC);
        check_frames("clean");

        window(tab[1], 4'b1000, 1'b0, 4);
        window(tab[2], 4'b0100, 1'b0, 4);
        window(tab[3], 4'b0010, 1'b0, 4);
        drain();
        #3 rst = 1'b1;
        #1;
        check("arst_hex", 64'(hex_out), 64'h0);
        check("arst_err", 64'(digit_err), 64'h0);
        check("arst_fv", 64'(frame_valid), 64'h0);
        check_frames("pre_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        scan(16'hDEF1, 4'b0000, 5);
        drain();
        check_frames("post_rst");
        check("post_hex", 64'(hex_out), 64'hDEF1);

        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < 10; k++) begin
                logic [6:0] s;
                logic [D-1:0] d;
                s = ($urandom_range(0, 99) < 85) ? tab[$urandom_range(0, 15)] : 7'($urandom);
                d = ($urandom_range(0, 99) < 85) ? D'(1) << $urandom_range(0, D - 1) : D'($urandom);
                window(s, d, 1'($urandom), int'($urandom_range(1, 6)));
            end
            drain();
            check_frames("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
